// File: rtl/bist_march_ctrl.sv
// March C- MBIST sequencer driving one single-port RAM and its comparator.
// Optional mismatch diagnostics are built when BIST_DIAG_EN is defined.

module bist_march_ctrl #(
   parameter int                ADDR_W = 4,
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] BG     = 8'h55
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   output logic [DATA_W-1:0] data_t,
   input  logic              eq
`ifdef BIST_DIAG_EN
   ,
   output logic [7:0]        fail_cnt,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_exp,
   output logic [2:0]        fail_elem
`endif
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WR   = 3'd1;
   localparam logic [2:0] S_RD   = 3'd2;
   localparam logic [2:0] S_CHK  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [ADDR_W-1:0] A_LAST = '1;

   logic [2:0]        state_q, state_d;
   logic [2:0]        elem_q, elem_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_t_q, data_t_d;
   logic              mis_q, mis_d;

   logic              down, last, nxt_down;
   logic [2:0]        nxt_elem;
   logic [DATA_W-1:0] rpat, wpat;
   logic [2:0]        adv_state;
   logic [2:0]        adv_elem;
   logic [ADDR_W-1:0] adv_addr;

`ifdef BIST_DIAG_EN
   logic [7:0]        fail_cnt_q, fail_cnt_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
   logic [2:0]        fail_elem_q, fail_elem_d;
`endif

   // Element decode and the step to the next address or element
   always_comb begin
      down     = (elem_q == 3'd3) || (elem_q == 3'd4);
      last     = down ? (addr_q == '0) : (addr_q == A_LAST);
      nxt_elem = elem_q + 3'd1;
      nxt_down = (nxt_elem == 3'd3) || (nxt_elem == 3'd4);
      rpat     = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~BG : BG;
      wpat     = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~BG : BG;
      adv_state = S_RD;
      adv_elem  = elem_q;
      adv_addr  = addr_q;
      if (!last) begin
         adv_addr  = down ? addr_q - 1'b1 : addr_q + 1'b1;
         adv_state = (elem_q == 3'd0) ? S_WR : S_RD;
      end else if (elem_q == 3'd5) begin
         adv_state = S_DONE;
      end else begin
         adv_elem = nxt_elem;
         adv_addr = nxt_down ? A_LAST : '0;
      end
   end

   // Next-state, sticky mismatch and diagnostic capture
   always_comb begin
      state_d  = state_q;
      elem_d   = elem_q;
      addr_d   = addr_q;
      data_t_d = data_t_q;
      mis_d    = mis_q;
`ifdef BIST_DIAG_EN
      fail_cnt_d  = fail_cnt_q;
      fail_addr_d = fail_addr_q;
      fail_exp_d  = fail_exp_q;
      fail_elem_d = fail_elem_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_WR;
               elem_d  = '0;
               addr_d  = '0;
               mis_d   = 1'b0;
`ifdef BIST_DIAG_EN
               fail_cnt_d  = '0;
               fail_addr_d = '0;
               fail_exp_d  = '0;
               fail_elem_d = '0;
`endif
            end
         end
         S_WR: begin
            state_d = adv_state;
            elem_d  = adv_elem;
            addr_d  = adv_addr;
         end
         S_RD: begin
            state_d  = S_CHK;
            data_t_d = rpat;
         end
         S_CHK: begin
            if (!eq) begin
               mis_d = 1'b1;
`ifdef BIST_DIAG_EN
               if (fail_cnt_q == 8'd0) begin
                  fail_addr_d = addr_q;
                  fail_exp_d  = data_t_q;
                  fail_elem_d = elem_q;
               end
               if (fail_cnt_q != 8'hFF)
                  fail_cnt_d = fail_cnt_q + 8'd1;
`endif
            end
            if (elem_q == 3'd5) begin
               state_d = adv_state;
               elem_d  = adv_elem;
               addr_d  = adv_addr;
            end else begin
               state_d = S_WR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         elem_q   <= '0;
         addr_q   <= '0;
         data_t_q <= '0;
         mis_q    <= 1'b0;
`ifdef BIST_DIAG_EN
         fail_cnt_q  <= '0;
         fail_addr_q <= '0;
         fail_exp_q  <= '0;
         fail_elem_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         elem_q   <= elem_d;
         addr_q   <= addr_d;
         data_t_q <= data_t_d;
         mis_q    <= mis_d;
`ifdef BIST_DIAG_EN
         fail_cnt_q  <= fail_cnt_d;
         fail_addr_q <= fail_addr_d;
         fail_exp_q  <= fail_exp_d;
         fail_elem_q <= fail_elem_d;
`endif
      end
   end

   // Outputs decoded from the registered state
   always_comb begin
      busy      = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_CHK);
      done      = (state_q == S_DONE);
      pass      = done && !mis_q;
      ram_we    = (state_q == S_WR);
      ram_re    = (state_q == S_RD);
      ram_addr  = addr_q;
      ram_wdata = ram_we ? wpat : '0;
      data_t    = data_t_q;
   end

`ifdef BIST_DIAG_EN
   assign fail_cnt  = fail_cnt_q;
   assign fail_addr = fail_addr_q;
   assign fail_exp  = fail_exp_q;
   assign fail_elem = fail_elem_q;
`endif

endmodule

// File: doc/bist_march_ctrl.md
Name: bist_march_ctrl

Overview:
- MBIST sequencer that runs the March C- algorithm over one synchronous single-port RAM.
- Drives RAM address, write data and read/write enables, and presents the expected word on data_t to bist_comparator.
- Samples the comparator eq result to build a sticky pass/fail status.
- Sits between the top-level BIST start/done interface and the RAM/comparator pair.

Parameters:
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, RAM word width; must match the bist_comparator width.
- BG, 8'h55, background pattern. March "0" = BG, March "1" = ~BG.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a test; sampled only in IDLE.
- busy  output  1  high while a test is in progress.
- done  output  1  high from test completion until the next accepted start.
- pass  output  1  valid when done=1; 1 = no mismatch detected.
- ram_addr  output  ADDR_W  RAM address.
- ram_wdata  output  DATA_W  RAM write data.
- ram_we  output  1  RAM write strobe.
- ram_re  output  1  RAM read strobe; ramout is valid on the following cycle.
- data_t  output  DATA_W  expected word, to comparator data_t.
- eq  input  1  comparator eq (data_t == ramout).
- fail_cnt  output  8  present only with BIST_DIAG_EN.
- fail_addr  output  ADDR_W  present only with BIST_DIAG_EN.
- fail_exp  output  DATA_W  present only with BIST_DIAG_EN.
- fail_elem  output  3  present only with BIST_DIAG_EN.

Behaviour:
- Clocking and reset: one clock domain (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE; busy=0, done=0, pass=0, ram_we=0, ram_re=0; ram_addr, ram_wdata and data_t = 0; all diagnostic outputs = 0.
- States:
  - IDLE: start=1 moves to WR or RD at element 0, address 0; busy=1 from the next cycle; done and pass cleared.
  - WR: 1 cycle; ram_we=1, ram_addr = current address, ram_wdata = the element's pattern.
  - RD: 1 cycle; ram_re=1, ram_addr = current address.
  - CHK: 1 cycle; data_t = expected pattern; eq is sampled at the end of CHK; eq=0 marks a mismatch.
  - DONE: busy=0, done=1; pass = NOT(any mismatch); stays here until start is accepted again (treated exactly as in IDLE).
- Elements, in order (up = 0..DEPTH-1, down = DEPTH-1..0):
  - E0 up(w0)
  - E1 up(r0, w1)
  - E2 up(r1, w0)
  - E3 down(r0, w1)
  - E4 down(r1, w0)
  - E5 up(r0)
- Sequencing:
  - Within an element, the operations on one address complete before the address advances.
  - The last operation at the last address of an element goes directly to the first operation of the next element, with no idle cycle.
- Run length: exactly 15*DEPTH cycles with busy=1 (DEPTH writes for E0, 3*DEPTH per element for E1-E4, 2*DEPTH for E5). done rises on the cycle after the last CHK.
- Outside their active cycles: ram_we=0 and ram_re=0; data_t holds its last value.
- A mismatch does not abort the test; it always runs to completion.
- start while busy=1 is ignored.
- rst asserted mid-test returns the block to IDLE at the next clock edge; a partial result is never reported.
- DEPTH=1: up and down sequences are identical; run length is 15 cycles.

Optional Feature:
- Macro BIST_DIAG_EN.
- Defined:
  - fail_cnt counts mismatches, saturating at 255.
  - On the first mismatch of a test, fail_addr, fail_exp (the data_t value) and fail_elem (0-5) are captured and then held.
  - All diagnostic registers clear on an accepted start and on rst.
- Undefined: the diagnostic ports and registers are absent; only pass/fail is reported.

Test Plan:
- ADDR_W=4, fault-free RAM model, start pulse → busy high for exactly 240 cycles, then done=1, pass=1; fail_cnt=0.
- Address 5 bit0 stuck-at-1 (BG=8'h55) → pass=0; fail_elem=2, fail_addr=5, fail_exp=8'hAA, fail_cnt=2 (E2 and E4 reads).
- Address 0 bit7 stuck-at-0 → first failure in E2 at address 0 with fail_exp=8'hAA; fail_cnt=2.
- rst asserted at cycle 100 of a run → next cycle busy=0, done=0, ram_we=0, ram_re=0; a new start gives a full 240-cycle run.
- start pulsed again at cycle 50 of a run → ignored; run length remains 240 cycles. start in DONE → done clears and a second run completes with the same result.
- Check ram_addr sequence in E3: 15,15,15,14,14,14…0 (RD, CHK, WR per address); ram_we asserted only in WR cycles with ram_wdata=8'hAA.
